seq_mult_ctrl: RTL and testbench
================================

// Module: seq_mult_ctrl
// PURPOSE
//   Shift-add unsigned multiplier sequencer in datapath/ALU.
//   Sits upstream of the ripple-carry adder: each cycle it feeds the adder the
//   running partial product and the multiplicand, then captures sum + carry-out.
//   Produces a 2*WIDTH-bit product after WIDTH add/shift steps, with a
//   valid/ready result handshake toward the ALU result mux.
// PARAMETERS
//   WIDTH   3   operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//   clk         in   1         single clock, all state updates on rising edge
//   rst         in   1         synchronous, active-high reset
//   start       in   1         request a multiply; sampled only in IDLE
//   a           in   WIDTH     multiplicand, captured on accepted start
//   b           in   WIDTH     multiplier, captured on accepted start
//   busy        out  1         high in RUN and DONE
//   prod_valid  out  1         product held and valid (DONE state)
//   prod_ready  in   1         consumer accepts product when high with prod_valid
//   product     out  2*WIDTH   a*b, unsigned
// BEHAVIOUR
//   - Reset: state=IDLE, busy=0, prod_valid=0, product=0, step count=0.
//     Reset wins over every other input in the same cycle; mid-operation reset
//     aborts, no partial product is ever presented.
//   - Registers: mcand[WIDTH-1:0], acc_hi[WIDTH-1:0], acc_lo[WIDTH-1:0]
//     (acc_lo initially holds multiplier), cnt[$clog2(WIDTH+1)-1:0].
//   - IDLE: start=1 at edge k -> mcand=a, acc_hi=0, acc_lo=b, cnt=0, state=RUN.
//     start=0 -> stay.
//   - RUN, per edge: {c,s} = acc_lo[0] ? acc_hi + mcand : {1'b0,acc_hi};
//     c is the adder carry-out (WIDTH-bit add, cin=0);
//     {acc_hi,acc_lo} <= {c, s, acc_lo[WIDTH-1:1]}; cnt<=cnt+1.
//     When cnt==WIDTH-1 on the edge, state<=DONE.
//   - Latency: start accepted at edge k -> prod_valid=1 after edge k+WIDTH
//     (WIDTH RUN cycles). product = {acc_hi,acc_lo}, registered, stable in DONE.
//   - DONE: prod_valid=1. prod_ready=1 at an edge -> IDLE, prod_valid=0 after
//     that edge; product register keeps last value. prod_ready=0 -> hold all.
//   - start while RUN or DONE: ignored (no queue, no restart, no error flag).
//     start in same cycle as DONE handoff: ignored; must be re-asserted in IDLE.
//   - prod_ready outside DONE: no effect.
//   - Carry-out of each add must be retained; dropping it is a spec violation
//     (max case (2^W-1)^2 exercises it).
// STRUCTURE
//   - Shared package alu_pkg: state encoding localparams ST_IDLE=2'd0,
//     ST_RUN=2'd1, ST_DONE=2'd2; ST 2'd3 unreachable -> treated as IDLE.
//   - One sub-module: nbit_adder #(WIDTH) (a,b,cin -> s,cout), a generate-loop
//     chain of FA cells with carry chained c[i]->c[i+1]; cin tied 0 here.
//   - FSM + datapath registers in this module; no combinational path from
//     start or prod_ready to any output.
// TESTING (WIDTH=3 unless noted)
//   1. rst, then a=3,b=5,start 1 cycle -> busy next cycle, prod_valid after 3
//      RUN edges, product=6'd15; prod_ready=1 -> IDLE next edge.
//   2. a=7,b=7 -> product=6'd49 (6'b110001); checks carry-out capture each step.
//   3. a=0,b=6 and a=5,b=0 -> product=0, same latency (3 cycles), no shortcut.
//   4. start held high through RUN with a=1,b=1 changed mid-run to 7,7 ->
//      product=1; exactly one operation; new start honoured only after IDLE.
//   5. Backpressure: result ready with prod_ready=0 for 5 cycles -> prod_valid
//      and product stable all 5; release -> single handoff.
//   6. rst asserted at 2nd RUN cycle -> next edge IDLE, busy=0, prod_valid=0,
//      product=0; fresh 2*3 then yields 6. Random 1000 ops WIDTH=3 and
//      WIDTH=8 vs a*b reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU datapath blocks.
//   Sequencer state encoding. Code 2'd3 is never entered; the multiplier
//   sequencer treats it exactly like IDLE so a corrupted state self-recovers.
package alu_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_BAD  = 2'd3;
endpackage

// File: rtl/seq_mult_ctrl_adder.sv
// nbit_adder: WIDTH-bit ripple-carry adder built from a chain of full-adder
// cells; carry c[i] feeds cell i+1.
//   a, b  in  WIDTH  addends
//   cin   in  1      carry into bit 0
//   s     out WIDTH  sum
//   cout  out 1      carry out of the top cell
module nbit_adder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: shift-add unsigned multiplier sequencer.
//   One add/shift step per RUN cycle through nbit_adder; after WIDTH steps the
//   2*WIDTH-bit product is registered and offered with a valid/ready handshake.
//   clk         in   1        rising-edge clock
//   rst         in   1        synchronous active-high reset
//   start       in   1        multiply request, honoured only in IDLE
//   a, b        in   WIDTH    multiplicand / multiplier, captured on start
//   busy        out  1        high in RUN and DONE
//   prod_valid  out  1        product valid (DONE)
//   prod_ready  in   1        consumer takes product when high in DONE
//   product     out  2*WIDTH  registered a*b; holds last value after handoff
module seq_mult_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0]   add_b, sum;
  logic               cout;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               is_idle;

  // Unreachable code 3 behaves as IDLE.
  assign is_idle = (state == ST_IDLE) || (state == ST_BAD);

  // Partial product + (multiplier bit ? multiplicand : 0); carry is kept as
  // the new top bit before the right shift.
  assign add_b   = acc_lo[0] ? mcand : '0;
  assign acc_nxt = {cout, sum, acc_lo[WIDTH-1:1]};

  nbit_adder #(.WIDTH(WIDTH)) u_add (
    .a    (acc_hi),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: if (prod_ready)  state_nxt = ST_IDLE;
      default: state_nxt = start ? ST_RUN : ST_IDLE;
    endcase
  end

  // Outputs decode from state only, so start/prod_ready never reach them
  // combinationally.
  always_comb begin
    busy       = 1'b0;
    prod_valid = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy       = 1'b1;
        prod_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath. product loads only on the final step, so a partial value is
  // never visible and the last result persists through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (is_idle && start) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      {acc_hi, acc_lo} <= acc_nxt;
      cnt              <= cnt + CW'(1);
      if (cnt == LAST) product <= acc_nxt;
    end
  end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // WIDTH=3 instance
  logic       rst3 = 1'b1, start3 = 1'b0, ready3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, pv3;
  logic [5:0] prod3;

  seq_mult_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .prod_valid(pv3), .prod_ready(ready3), .product(prod3)
  );

  // WIDTH=8 instance
  logic        rst8 = 1'b1, start8 = 1'b0, ready8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, pv8;
  logic [15:0] prod8;

  seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .prod_valid(pv8), .prod_ready(ready8), .product(prod8)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst3 = 1'b1; rst8 = 1'b1;
    tick(); tick();
    checks++;
    if (busy3 !== 1'b0 || pv3 !== 1'b0 || prod3 !== 6'd0) begin
      failures++;
      $display("FAIL reset_w3 busy=%b pv=%b prod=%0d required 0/0/0", busy3, pv3, prod3);
    end
    checks++;
    if (busy8 !== 1'b0 || pv8 !== 1'b0 || prod8 !== 16'd0) begin
      failures++;
      $display("FAIL reset_w8 busy=%b pv=%b prod=%0d required 0/0/0", busy8, pv8, prod8);
    end
    rst3 = 1'b0; rst8 = 1'b0;
    tick();
  endtask

  // Full WIDTH=3 operation with exact latency and handoff checks.
  task automatic do_op3(input logic [2:0] ia, input logic [2:0] ib,
                        input logic [5:0] exp, input string nm);
    a3 = ia; b3 = ib; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    checks++;
    if (busy3 !== 1'b1 || pv3 !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept busy=%b pv=%b required 1/0", nm, busy3, pv3);
    end
    tick(); tick();
    checks++;
    if (pv3 !== 1'b0) begin
      failures++;
      $display("FAIL %s_early pv=%b required 0", nm, pv3);
    end
    tick();
    checks++;
    if (pv3 !== 1'b1 || prod3 !== exp) begin
      failures++;
      $display("FAIL %s_result pv=%b prod=%0d required 1/%0d", nm, pv3, prod3, exp);
    end
    ready3 = 1'b1;
    tick();
    ready3 = 1'b0;
    checks++;
    if (pv3 !== 1'b0 || busy3 !== 1'b0 || prod3 !== exp) begin
      failures++;
      $display("FAIL %s_handoff pv=%b busy=%b prod=%0d required 0/0/%0d", nm, pv3, busy3, prod3, exp);
    end
  endtask

  task automatic test_basic();
    do_op3(3'd3, 3'd5, 6'd15, "mul3x5");
  endtask

  task automatic test_carry();
    do_op3(3'd7, 3'd7, 6'd49, "mul7x7");
    do_op3(3'd6, 3'd7, 6'd42, "mul6x7");
  endtask

  task automatic test_zero();
    do_op3(3'd0, 3'd6, 6'd0, "mul0x6");
    do_op3(3'd5, 3'd0, 6'd0, "mul5x0");
  endtask

  task automatic test_start_held();
    a3 = 3'd1; b3 = 3'd1; start3 = 1'b1;
    tick();
    a3 = 3'd7; b3 = 3'd7;
    tick(); tick(); tick();
    checks++;
    if (pv3 !== 1'b1 || prod3 !== 6'd1) begin
      failures++;
      $display("FAIL held_result pv=%b prod=%0d required 1/1", pv3, prod3);
    end
    // start still high across the handoff edge: must land in IDLE
    ready3 = 1'b1;
    tick();
    ready3 = 1'b0;
    checks++;
    if (busy3 !== 1'b0 || pv3 !== 1'b0) begin
      failures++;
      $display("FAIL held_handoff busy=%b pv=%b required 0/0", busy3, pv3);
    end
    // now in IDLE with start high: accepted at this edge, operands 7,7
    tick();
    start3 = 1'b0;
    checks++;
    if (busy3 !== 1'b1) begin
      failures++;
      $display("FAIL held_restart busy=%b required 1", busy3);
    end
    tick(); tick(); tick();
    checks++;
    if (pv3 !== 1'b1 || prod3 !== 6'd49) begin
      failures++;
      $display("FAIL held_second pv=%b prod=%0d required 1/49", pv3, prod3);
    end
    ready3 = 1'b1;
    tick();
    ready3 = 1'b0;
  endtask

  task automatic test_backpressure();
    a3 = 3'd6; b3 = 3'd5; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pv3 !== 1'b1 || prod3 !== 6'd30) begin
        failures++;
        $display("FAIL bp_hold%0d pv=%b prod=%0d required 1/30", i, pv3, prod3);
      end
      tick();
    end
    ready3 = 1'b1;
    tick();
    checks++;
    if (pv3 !== 1'b0 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL bp_release pv=%b busy=%b required 0/0", pv3, busy3);
    end
    // ready left high in IDLE must not disturb anything
    tick();
    ready3 = 1'b0;
    checks++;
    if (pv3 !== 1'b0 || busy3 !== 1'b0 || prod3 !== 6'd30) begin
      failures++;
      $display("FAIL bp_single pv=%b busy=%b prod=%0d required 0/0/30", pv3, busy3, prod3);
    end
  endtask

  task automatic test_mid_reset();
    a3 = 3'd7; b3 = 3'd6; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    checks++;
    if (busy3 !== 1'b0 || pv3 !== 1'b0 || prod3 !== 6'd0) begin
      failures++;
      $display("FAIL midrst busy=%b pv=%b prod=%0d required 0/0/0", busy3, pv3, prod3);
    end
    tick(); tick(); tick();
    checks++;
    if (busy3 !== 1'b0 || pv3 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stay busy=%b pv=%b required 0/0", busy3, pv3);
    end
    do_op3(3'd2, 3'd3, 6'd6, "mul2x3");
  endtask

  task automatic test_random3();
    logic [2:0] ra, rb;
    logic [5:0] exp;
    for (int n = 0; n < 1000; n++) begin
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      exp = 6'(ra) * 6'(rb);
      a3 = ra; b3 = rb; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (pv3 !== 1'b1 || prod3 !== exp) begin
        failures++;
        $display("FAIL rand3 a=%0d b=%0d pv=%b prod=%0d required 1/%0d", ra, rb, pv3, prod3, exp);
      end
      ready3 = 1'b1;
      tick();
      ready3 = 1'b0;
    end
  endtask

  task automatic test_random8();
    logic [7:0]  ra, rb;
    logic [15:0] exp;
    for (int n = 0; n < 1002; n++) begin
      if (n == 0)      begin ra = 8'd255; rb = 8'd255; end
      else if (n == 1) begin ra = 8'd0;   rb = 8'd255; end
      else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
      end
      exp = 16'(ra) * 16'(rb);
      a8 = ra; b8 = rb; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (7) tick();
      checks++;
      if (pv8 !== 1'b0) begin
        failures++;
        $display("FAIL rand8_early a=%0d b=%0d pv=%b required 0", ra, rb, pv8);
      end
      tick();
      checks++;
      if (pv8 !== 1'b1 || prod8 !== exp) begin
        failures++;
        $display("FAIL rand8 a=%0d b=%0d pv=%b prod=%0d required 1/%0d", ra, rb, pv8, prod8, exp);
      end
      ready8 = 1'b1;
      tick();
      ready8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_start_held();
    test_backpressure();
    test_mid_reset();
    test_random3();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
